dircc_multi_channel_timer: RTL and testbench
============================================

// Module: dircc_multi_channel_timer
// PURPOSE
//  Parametrised N-channel interval timer; Avalon-MM slave on each node's Nios II.
//  Each channel has a COUNTER_WIDTH down-counter, its own period, prescale, one-shot/continuous mode, snapshot and IRQ enable.
//  Feeds per-channel IRQs (irq_vec) and a combined irq to the node processor.
// PARAMETERS
//  NUM_CHANNELS   4      timer channels, 1..8
//  COUNTER_WIDTH  32     counter/period width, 16..32
//  RESET_PERIOD   49999  reset value of every PERIOD register and counter
//  PSC_WIDTH      16     shared free-running prescaler width
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      reset, asynchronous, active-low
//  address    in   CH_AW+2  {channel, reg[1:0]}; CH_AW = max(1,clog2(NUM_CHANNELS))
//  chipselect in   1      slave select
//  write_n    in   1      active-low write
//  writedata  in   32     write data
//  readdata   out  32     registered read data
//  irq_vec    out  NUM_CHANNELS  per-channel interrupt (TO & ITO)
//  irq        out  1      OR of irq_vec
// BEHAVIOUR
//  Reg map per channel: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAPSHOT. Unused bits read 0.
//  Channel index >= NUM_CHANNELS: writes ignored, reads return 0.
//  STATUS: [0] TO (write 1 clears), [1] RUN (read-only).
//  CONTROL: [0] ITO, [1] CONT, [2] START (write-only, reads 0), [3] STOP (write-only, reads 0), [7:4] PSC.
//  PERIOD: COUNTER_WIDTH bits, zero-extended on read; writedata upper bits dropped.
//  Read latency 1 cycle: readdata registered, updated every cycle from address; 0 after reset.
//  Prescaler: PSC_WIDTH free-running counter, 0 at reset, wraps.
//   ch tick = prescaler[PSC-1:0] all ones; PSC=0 -> every cycle; PSC>PSC_WIDTH clamps to PSC_WIDTH.
//  Counting (per channel, on tick while RUN):
//   counter!=0 -> counter-1.
//   counter==0 -> counter<=PERIOD; TO<=1; if !CONT, RUN<=0.
//   Period = (PERIOD+1) ticks; PERIOD=0 in CONT -> TO every tick.
//  CONTROL write: START=1 -> RUN<=1; else STOP=1 -> RUN<=0; START and STOP together -> start wins.
//  PERIOD write: PERIOD and counter both <= writedata same edge; RUN<=0 (overrides START from any other source).
//  SNAPSHOT write (any data): snapshot <= live counter value at that edge. Read returns the captured value; 0 at reset.
//  TO clear and timeout on same cycle -> TO=1 (new event never lost).
//  irq_vec[i] = TO[i] & ITO[i], combinational from registers; irq = |irq_vec.
//  Reset (async, any time): counters=RESET_PERIOD, PERIOD=RESET_PERIOD, CONTROL=0, RUN=0, TO=0, snapshot=0, readdata=0, irq_vec=0, irq=0.
//  Channels are fully independent; only the prescaler is shared.
// TESTING
//  Reset, read ch0 PERIOD -> 49999 one cycle after read; STATUS=0; irq=0.
//  ch1 PERIOD=9, CONTROL=0x7 (ITO,CONT,START) -> TO every 10 clks; irq_vec[1] high; write STATUS=1 clears it for 1 period.
//  ch2 PERIOD=3, CONTROL=0x5 (one-shot) -> TO after 4 clks; RUN=0; counter stays 3.
//  ch0 PSC=2, PERIOD=1, CONT+START -> ticks every 4 clks; TO every 8 clks.
//  TO clear written in same cycle counter hits 0 -> TO reads 1.
//  PERIOD write while running -> RUN=0, counter=new value.
//  SNAPSHOT write mid-count -> snapshot read = counter at write edge.
//  Async reset asserted mid-count -> all outputs 0 immediately; counter=49999.

Source files
------------

// File: rtl/dircc_multi_channel_timer.sv
// N-channel interval timer with an Avalon-MM register window per channel.
// Each channel is a prescaled down-counter with period reload, one-shot/continuous mode, snapshot and IRQ.
module dircc_multi_channel_timer #(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int RESET_PERIOD  = 49999,
    parameter int PSC_WIDTH     = 16,
    localparam int CH_AW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CH_AW+1:0]        address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_CHANNELS-1:0] irq_vec,
    output logic                    irq
);

    localparam logic [COUNTER_WIDTH-1:0] RST_VAL = COUNTER_WIDTH'(RESET_PERIOD);

    // A channel ticks when the low PSC prescaler bits are all ones; PSC beyond PSC_WIDTH clamps.
    function automatic logic psc_tick(input logic [PSC_WIDTH-1:0] cnt, input logic [3:0] psc);
        logic [PSC_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < PSC_WIDTH; b++) begin
            mask[b] = (b < int'(psc));
        end
        return (cnt & mask) == mask;
    endfunction

    logic [PSC_WIDTH-1:0]     prescaler;
    logic [CH_AW-1:0]         ch;
    logic [1:0]               reg_sel;
    logic                     wr;
    logic [COUNTER_WIDTH-1:0] cnt_a  [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] per_a  [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] snap_a [NUM_CHANNELS];
    logic [3:0]               psc_a  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  run_v, to_v, ito_v, cont_v;
    logic [31:0]              rd_mux;

    assign ch      = address[CH_AW+1:2];
    assign reg_sel = address[1:0];
    assign wr      = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prescaler <= '0;
        else          prescaler <= prescaler + 1'b1;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] cnt_r, per_r, snap_r;
        logic [3:0]               psc_r;
        logic                     run_r, to_r, ito_r, cont_r;
        logic                     sel, tick, timeout;

        assign sel     = wr && (ch == CH_AW'(i));
        assign tick    = psc_tick(prescaler, psc_r);
        assign timeout = tick && run_r && (cnt_r == '0);

        // Later assignments take priority: register writes override the counting update.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_r  <= RST_VAL;
                per_r  <= RST_VAL;
                snap_r <= '0;
                psc_r  <= '0;
                run_r  <= 1'b0;
                to_r   <= 1'b0;
                ito_r  <= 1'b0;
                cont_r <= 1'b0;
            end else begin
                if (tick && run_r) begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - 1'b1;
                    end else begin
                        cnt_r <= per_r;
                        if (!cont_r) run_r <= 1'b0;
                    end
                end
                if (timeout)                                  to_r <= 1'b1;
                else if (sel && reg_sel == 2'd0 && writedata[0]) to_r <= 1'b0;
                if (sel && reg_sel == 2'd1) begin
                    ito_r  <= writedata[0];
                    cont_r <= writedata[1];
                    psc_r  <= writedata[7:4];
                    if (writedata[2])      run_r <= 1'b1;
                    else if (writedata[3]) run_r <= 1'b0;
                end
                if (sel && reg_sel == 2'd2) begin
                    per_r <= writedata[COUNTER_WIDTH-1:0];
                    cnt_r <= writedata[COUNTER_WIDTH-1:0];
                    run_r <= 1'b0;
                end
                if (sel && reg_sel == 2'd3) snap_r <= cnt_r;
            end
        end

        assign cnt_a[i]  = cnt_r;
        assign per_a[i]  = per_r;
        assign snap_a[i] = snap_r;
        assign psc_a[i]  = psc_r;
        assign run_v[i]  = run_r;
        assign to_v[i]   = to_r;
        assign ito_v[i]  = ito_r;
        assign cont_v[i] = cont_r;
    end

    // Unmatched channel indices fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch == CH_AW'(i)) begin
                case (reg_sel)
                    2'd0:    rd_mux = {30'b0, run_v[i], to_v[i]};
                    2'd1:    rd_mux = {24'b0, psc_a[i], 2'b0, cont_v[i], ito_v[i]};
                    2'd2:    rd_mux = 32'(per_a[i]);
                    default: rd_mux = 32'(snap_a[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq_vec = to_v & ito_v;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_dircc_multi_channel_timer.sv
// Directed bench for dircc_multi_channel_timer: a cycle model built from the register rules
// is compared against readdata/irq_vec/irq every cycle, plus hand-computed literal checks.
module tb_dircc_multi_channel_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  irq_vec;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    // Model state, plain integers per channel
    int unsigned m_cnt[4], m_per[4], m_snap[4];
    int          m_psc[4];
    bit          m_run[4], m_to[4], m_ito[4], m_cont[4];
    int unsigned m_cyc;
    logic [31:0] m_rd;

    dircc_multi_channel_timer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_vec(irq_vec), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 49999; m_per[i] = 49999; m_snap[i] = 0; m_psc[i] = 0;
            m_run[i] = 0; m_to[i] = 0; m_ito[i] = 0; m_cont[i] = 0;
        end
        m_cyc = 0;
        m_rd = '0;
    endtask

    function automatic logic [31:0] mread(input int c, input int r);
        case (r)
            0:       return {30'b0, m_run[c], m_to[c]};
            1:       return {24'b0, 4'(m_psc[c]), 2'b0, m_cont[c], m_ito[c]};
            2:       return m_per[c];
            default: return m_snap[c];
        endcase
    endfunction

    function automatic logic [3:0] m_irqv();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_to[i] & m_ito[i];
        return v;
    endfunction

    // One clock edge of the rules, evaluated from pre-edge state and the stable inputs.
    task automatic model_step();
        int  c, r, eff, period_len;
        bit  we, tk, ev, sel;
        int unsigned ncnt;
        bit  nrun, nto;
        c  = int'(address[3:2]);
        r  = int'(address[1:0]);
        we = chipselect && !write_n;
        m_rd = mread(c, r);
        for (int i = 0; i < 4; i++) begin
            eff = (m_psc[i] > 16) ? 16 : m_psc[i];
            period_len = 1 << eff;
            tk   = (m_cyc % period_len) == period_len - 1;
            ev   = tk && m_run[i] && m_cnt[i] == 0;
            ncnt = m_cnt[i]; nrun = m_run[i]; nto = m_to[i];
            if (tk && m_run[i]) begin
                if (m_cnt[i] == 0) begin
                    ncnt = m_per[i];
                    if (!m_cont[i]) nrun = 0;
                end else begin
                    ncnt = m_cnt[i] - 1;
                end
            end
            sel = we && (c == i);
            if (sel && r == 0 && writedata[0]) nto = 0;
            if (ev) nto = 1;
            if (sel && r == 1) begin
                m_ito[i] = writedata[0]; m_cont[i] = writedata[1]; m_psc[i] = int'(writedata[7:4]);
                if (writedata[2]) nrun = 1;
                else if (writedata[3]) nrun = 0;
            end
            if (sel && r == 2) begin
                m_per[i] = writedata; ncnt = writedata; nrun = 0;
            end
            if (sel && r == 3) m_snap[i] = m_cnt[i];
            m_cnt[i] = ncnt; m_run[i] = nrun; m_to[i] = nto;
        end
        m_cyc = (m_cyc + 1) % 65536;
    endtask

    // Advance one clock: model follows the edge, DUT outputs compared on the falling edge.
    task automatic clk1();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        @(negedge clk);
        chk("readdata", readdata, m_rd);
        chk("irq_vec", 32'(irq_vec), 32'(m_irqv()));
        chk("irq", 32'(irq), 32'(|m_irqv()));
    endtask

    task automatic wr(input int c, input int r, input logic [31:0] d);
        address = {2'(c), 2'(r)}; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        clk1();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int c, input int r, output logic [31:0] d);
        address = {2'(c), 2'(r)}; chipselect = 1'b1; write_n = 1'b1;
        clk1();
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int n;
        model_reset();
        repeat (3) clk1();
        reset_n = 1'b1;

        // Reset state
        rd(0, 2, d); chk("reset_period_ch0", d, 32'd49999);
        rd(0, 0, d); chk("reset_status_ch0", d, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // ch1 continuous, period 10 clocks, IRQ enabled
        wr(1, 2, 32'd9); wr(1, 1, 32'h7);
        repeat (9) clk1();
        chk("ch1_no_to_before_10", 32'(irq_vec[1]), 32'd0);
        clk1();
        chk("ch1_to_at_10", 32'(irq_vec[1]), 32'd1);
        chk("irq_or", 32'(irq), 32'd1);
        wr(1, 0, 32'd1);
        chk("ch1_to_cleared", 32'(irq_vec[1]), 32'd0);
        repeat (8) clk1();
        chk("ch1_still_clear", 32'(irq_vec[1]), 32'd0);
        clk1();
        chk("ch1_to_again", 32'(irq_vec[1]), 32'd1);
        wr(1, 1, 32'h8); wr(1, 0, 32'd1);

        // ch2 one-shot
        wr(2, 2, 32'd3); wr(2, 1, 32'h5);
        repeat (3) clk1();
        chk("ch2_no_to_yet", 32'(irq_vec[2]), 32'd0);
        clk1();
        chk("ch2_to_after_4", 32'(irq_vec[2]), 32'd1);
        repeat (5) clk1();
        rd(2, 0, d); chk("ch2_status_stopped", d, 32'd1);
        wr(2, 3, 32'd0); rd(2, 3, d); chk("ch2_counter_held", d, 32'd3);
        wr(2, 0, 32'd1);

        // ch0 PSC=2: tick every 4 clocks, TO every 8
        wr(0, 2, 32'd1); wr(0, 1, 32'h27);
        n = 0;
        while (!irq_vec[0] && n < 40) begin clk1(); n++; end
        chk("ch0_first_to_seen", 32'(irq_vec[0]), 32'd1);
        wr(0, 0, 32'd1);
        n = 1;
        while (!irq_vec[0] && n < 40) begin clk1(); n++; end
        chk("ch0_to_interval", 32'(n), 32'd8);

        // Clear written on the very edge of the next timeout: TO must survive
        wr(0, 0, 32'd1);
        repeat (6) clk1();
        wr(0, 0, 32'd1);
        rd(0, 0, d); chk("to_clear_vs_timeout", d, 32'd3);

        // PERIOD write while running stops the channel and loads the counter
        wr(0, 2, 32'd100);
        rd(0, 0, d); chk("period_write_stops", d, 32'd1);
        wr(0, 3, 32'd0); rd(0, 3, d); chk("period_write_counter", d, 32'd100);

        // START and STOP together: start wins, command bits read back 0
        wr(1, 1, 32'hF);
        rd(1, 0, d); chk("start_wins_run", d & 32'h2, 32'h2);
        rd(1, 1, d); chk("control_readback", d, 32'h3);

        // Snapshot mid-count
        wr(3, 2, 32'd1000); wr(3, 1, 32'h4);
        repeat (5) clk1();
        wr(3, 3, 32'd0);
        rd(3, 3, d); chk("snapshot_mid_count", d, 32'd995);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_readdata", readdata, 32'd0);
        chk("async_rst_irq_vec", 32'(irq_vec), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        clk1();
        reset_n = 1'b1;
        rd(3, 2, d); chk("post_rst_period", d, 32'd49999);
        wr(3, 3, 32'd0); rd(3, 3, d); chk("post_rst_counter", d, 32'd49999);
        rd(3, 0, d); chk("post_rst_status", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
